// File: rtl/aci_indirgeyici.sv
// Range reduction of a Q16.16 angle modulo pi into (-pi/2, pi/2) with a tangent pole flag.
// Define KUTUP_KONTROL_EN to enable the guard-band pole check on gecerli_o.
module aci_indirgeyici #(
   parameter int unsigned PI_Q       = 205887,
   parameter int unsigned KUTUP_BANT = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] sayi1_i,
   input  logic        basla_i,
   output logic        mesgul_o,
   output logic [31:0] sonuc_o,
   output logic        hazir_o,
   output logic        gecerli_o
);

   typedef enum logic [1:0] {StBos, StBol, StDuzelt} durum_e;

   localparam logic [32:0] PiW   = 33'(PI_Q);
   localparam logic [32:0] Yarim = 33'((PI_Q + 32'd1) >> 1);
`ifdef KUTUP_KONTROL_EN
   localparam logic [31:0] Esik  = 32'(((PI_Q + 32'd1) >> 1) - KUTUP_BANT);
`endif

   durum_e      durum_q, durum_d;
   logic        isaret_q, isaret_d;
   logic [31:0] mag_q, mag_d;
   logic [32:0] kalan_q, kalan_d;
   logic [4:0]  sayac_q, sayac_d;
   logic [31:0] sonuc_q, sonuc_d;
   logic        hazir_q, hazir_d;
   logic        gecerli_q, gecerli_d;

   logic [32:0] t;
   logic [31:0] r_duz;
   logic [31:0] r_isr;
`ifdef KUTUP_KONTROL_EN
   logic [31:0] r_abs;
`endif

   always_comb begin
      durum_d   = durum_q;
      isaret_d  = isaret_q;
      mag_d     = mag_q;
      kalan_d   = kalan_q;
      sayac_d   = sayac_q;
      sonuc_d   = sonuc_q;
      hazir_d   = 1'b0;
      gecerli_d = gecerli_q;
      t         = '0;
      r_duz     = '0;
      r_isr     = '0;
`ifdef KUTUP_KONTROL_EN
      r_abs     = '0;
`endif
      unique case (durum_q)
         StBos: begin
            if (basla_i) begin
               durum_d  = StBol;
               isaret_d = sayi1_i[31];
               // Unsigned magnitude: -2^31 maps cleanly to 2^31
               mag_d    = sayi1_i[31] ? (~sayi1_i + 32'd1) : sayi1_i;
               kalan_d  = '0;
               sayac_d  = 5'd31;
            end
         end
         StBol: begin
            t       = {kalan_q[31:0], mag_q[sayac_q]};
            kalan_d = (t >= PiW) ? (t - PiW) : t;
            if (sayac_q == 5'd0) begin
               durum_d = StDuzelt;
            end else begin
               sayac_d = sayac_q - 5'd1;
            end
         end
         StDuzelt: begin
            // Fold [0, pi) onto [-pi/2, pi/2]
            r_duz   = (kalan_q >= Yarim) ? 32'(kalan_q - PiW) : kalan_q[31:0];
            r_isr   = isaret_q ? (~r_duz + 32'd1) : r_duz;
            sonuc_d = r_isr;
            hazir_d = 1'b1;
`ifdef KUTUP_KONTROL_EN
            r_abs     = r_duz[31] ? (~r_duz + 32'd1) : r_duz;
            gecerli_d = (r_abs < Esik);
`else
            gecerli_d = 1'b1;
`endif
            durum_d = StBos;
         end
         default: durum_d = StBos;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_q   <= StBos;
         isaret_q  <= 1'b0;
         mag_q     <= '0;
         kalan_q   <= '0;
         sayac_q   <= '0;
         sonuc_q   <= '0;
         hazir_q   <= 1'b0;
         gecerli_q <= 1'b0;
      end else begin
         durum_q   <= durum_d;
         isaret_q  <= isaret_d;
         mag_q     <= mag_d;
         kalan_q   <= kalan_d;
         sayac_q   <= sayac_d;
         sonuc_q   <= sonuc_d;
         hazir_q   <= hazir_d;
         gecerli_q <= gecerli_d;
      end
   end

   assign mesgul_o  = (durum_q != StBos);
   assign sonuc_o   = sonuc_q;
   assign hazir_o   = hazir_q;
   assign gecerli_o = gecerli_q;

endmodule

// File: tb/tb_aci_indirgeyici.sv
// Self-checking bench for aci_indirgeyici: vector table, random vs. arithmetic model, protocol.
module tb_aci_indirgeyici;

   logic        clk = 1'b0;
   logic        rst;
   logic        basla;
   logic [31:0] sayi1;
   logic        mesgul;
   logic [31:0] sonuc;
   logic        hazir;
   logic        gecerli;

   int total = 0;
   int bad   = 0;

   aci_indirgeyici dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .sayi1_i   (sayi1),
      .basla_i   (basla),
      .mesgul_o  (mesgul),
      .sonuc_o   (sonuc),
      .hazir_o   (hazir),
      .gecerli_o (gecerli)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] giris;
      logic [31:0] sonuc;
      logic        bantta;
   } vek_t;

   vek_t        tablo [10];
   logic [31:0] q_giris [$];
   int          q_cyc [$];
   logic [31:0] res, er, v;
   logic        g, eg;
   int          got, hz;
   longint      sabs;

   task automatic chk(input string ad, input logic [31:0] act, input logic [31:0] beklenen);
      total++;
      if (act !== beklenen) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", ad, act, beklenen);
      end
   endtask

   // Reference: plain modular arithmetic on the magnitude, then fold and sign
   function automatic void ref_model(input logic [31:0] x, output logic [31:0] r,
                                     output logic gv);
      longint vv, m, rem, a;
      vv  = longint'($signed(x));
      m   = (vv < 0) ? -vv : vv;
      rem = m % 205887;
      if (rem >= 102944) rem = rem - 205887;
      if (vv < 0) rem = -rem;
      r   = rem[31:0];
      a   = (rem < 0) ? -rem : rem;
`ifdef KUTUP_KONTROL_EN
      gv  = (a >= 102880) ? 1'b0 : 1'b1;
`else
      gv  = (a >= 0) ? 1'b1 : 1'b0;
`endif
   endfunction

   task automatic run_op(input logic [31:0] val, output logic [31:0] r, output logic gv);
      int          n;
      logic        seen;
      logic        stable;
      logic        busy1;
      logic [31:0] prev;
      @(negedge clk);
      sayi1 = val;
      basla = 1'b1;
      prev  = sonuc;
      @(posedge clk);
      #1;
      basla = 1'b0;
      sayi1 = ~val;
      n = 0; seen = 1'b0; stable = 1'b1; busy1 = 1'b0;
      while (!seen && n < 60) begin
         @(negedge clk);
         n++;
         if (n == 1) busy1 = mesgul;
         if (hazir) seen = 1'b1;
         else if (sonuc !== prev) stable = 1'b0;
      end
      chk("latency", 32'(n), 32'd34);
      chk("mesgul_busy", {31'd0, busy1}, 32'd1);
      chk("sonuc_stable", {31'd0, stable}, 32'd1);
      chk("mesgul_at_hazir", {31'd0, mesgul}, 32'd0);
      r  = sonuc;
      gv = gecerli;
      @(negedge clk);
      chk("hazir_pulse", {31'd0, hazir}, 32'd0);
   endtask

   initial begin
      tablo[0] = '{32'd65536,   32'd65536,    1'b0};
      tablo[1] = '{32'd238655,  32'd32768,    1'b0};
      tablo[2] = '{32'd131072,  -32'sd74815,  1'b0};
      tablo[3] = '{32'd0,       32'd0,        1'b0};
      tablo[4] = '{-32'sd65536, -32'sd65536,  1'b0};
      tablo[5] = '{32'd102900,  32'd102900,   1'b1};
      tablo[6] = '{32'd102879,  32'd102879,   1'b0};
      tablo[7] = '{32'd205887,  32'd0,        1'b0};
      tablo[8] = '{32'd102944,  -32'sd102943, 1'b1};
      tablo[9] = '{32'd102943,  32'd102943,   1'b1};

      rst = 1'b1; basla = 1'b0; sayi1 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_sonuc", sonuc, 32'd0);
      chk("rst_hazir", {31'd0, hazir}, 32'd0);
      chk("rst_gecerli", {31'd0, gecerli}, 32'd0);
      chk("rst_mesgul", {31'd0, mesgul}, 32'd0);

      for (int i = 0; i < 10; i++) begin
         run_op(tablo[i].giris, res, g);
`ifdef KUTUP_KONTROL_EN
         eg = ~tablo[i].bantta;
`else
         eg = 1'b1;
`endif
         chk("tbl_sonuc", res, tablo[i].sonuc);
         chk("tbl_gecerli", {31'd0, g}, {31'd0, eg});
      end

      run_op(32'h8000_0000, res, g);
      ref_model(32'h8000_0000, er, eg);
      chk("min_sonuc", res, er);
      chk("min_gecerli", {31'd0, g}, {31'd0, eg});
      chk("min_noX", {31'd0, $isunknown({res, g})}, 32'd0);
      sabs = longint'($signed(res));
      if (sabs < 0) sabs = -sabs;
      chk("min_range", {31'd0, sabs <= 102943}, 32'd1);

      for (int i = 0; i < 30; i++) begin
         v = (i % 3 == 0) ? 32'($urandom_range(0, 411774)) : $urandom;
         if (i % 3 == 1) v = -32'($urandom_range(0, 411774));
         run_op(v, res, g);
         ref_model(v, er, eg);
         chk("rnd_sonuc", res, er);
         chk("rnd_gecerli", {31'd0, g}, {31'd0, eg});
      end

      // basla held high with the input changing every cycle
      got = 0;
      for (int c = 0; c < 110; c++) begin
         @(negedge clk);
         if (hazir) begin
            if (q_giris.size() > 0) begin
               v = q_giris.pop_front();
               ref_model(v, er, eg);
               chk("bb_sonuc", sonuc, er);
               chk("bb_gecerli", {31'd0, gecerli}, {31'd0, eg});
               got++;
            end else begin
               chk("bb_spurious", {31'd0, hazir}, 32'd0);
            end
         end
         if (c < 70) begin
            basla = 1'b1;
            sayi1 = ((c % 2) != 0) ? (32'd300000 + 32'(c)) : (-32'sd500000 - 32'(c));
            if (!mesgul) begin
               q_giris.push_back(sayi1);
               q_cyc.push_back(c);
            end
         end else begin
            basla = 1'b0;
         end
      end
      chk("bb_accepts", 32'(q_cyc.size()), 32'd3);
      chk("bb_results", 32'(got), 32'd3);
      for (int i = 1; i < q_cyc.size(); i++) begin
         chk("bb_interval", 32'(q_cyc[i] - q_cyc[i-1]), 32'd34);
      end

      // rst and basla on the same edge
      @(negedge clk);
      rst = 1'b1; basla = 1'b1; sayi1 = 32'd65536;
      @(negedge clk);
      rst = 1'b0; basla = 1'b0;
      chk("rb_mesgul", {31'd0, mesgul}, 32'd0);
      hz = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (hazir || mesgul) hz++;
      end
      chk("rb_idle", 32'(hz), 32'd0);

      // rst in the middle of the loop
      run_op(32'd131072, res, g);
      @(negedge clk);
      sayi1 = 32'd65536; basla = 1'b1;
      @(posedge clk);
      #1 basla = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("ab_sonuc", sonuc, 32'd0);
      chk("ab_hazir", {31'd0, hazir}, 32'd0);
      chk("ab_gecerli", {31'd0, gecerli}, 32'd0);
      chk("ab_mesgul", {31'd0, mesgul}, 32'd0);
      hz = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (hazir) hz++;
      end
      chk("ab_nohazir", 32'(hz), 32'd0);
      run_op(32'd65536, res, g);
      chk("ab_after", res, 32'd65536);
      chk("ab_after_g", {31'd0, g}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aci_indirgeyici.md
# aci_indirgeyici

Sequential argument range-reduction stage that sits directly upstream of the tangent series evaluator. It accepts a signed Q16.16 angle in radians and reduces it modulo π into the interval (−π/2, π/2) using a 32-step shift-subtract remainder loop. It then presents the reduced angle with a one-cycle `hazir` strobe and a `gecerli` flag. `gecerli` drops when the reduced angle lies inside a guard band around ±π/2, where tangent diverges.

## Interface
- `PI_Q`, 205887: π in Q16.16, unsigned.
- `KUTUP_BANT`, 64: guard-band width in LSBs below π/2 used for pole detection.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sayi1` in 32: signed Q16.16 input angle, radians.
- `basla` in 1: start request; sampled only when `mesgul`=0.
- `mesgul` out 1: high while a reduction is in progress.
- `sonuc` out 32: signed Q16.16 reduced angle; held until the next completion.
- `hazir` out 1: one-cycle pulse when `sonuc` is updated.
- `gecerli` out 1: qualifies `sonuc` as usable for tangent; meaningful when `hazir`=1.

## Operation
- The block has one clock and a synchronous, active-high reset: `clk` and `rst`.
- Reset values: `sonuc`=0, `hazir`=0, `gecerli`=0, `mesgul`=0, state=BOS. All internal registers are cleared.
- States:
  - BOS (idle).
  - BOL (remainder loop).
  - DUZELT (fold, sign, output).
- BOS → BOL when `basla`=1. On that edge:
  - Capture `isaret`=`sayi1[31]`.
  - Capture magnitude `mag`=|`sayi1`| as 32-bit unsigned, so −2^31 gives 2^31 with no overflow.
  - Clear `kalan` (33-bit) and set the bit counter to 31.
- BOL, one iteration per cycle, bit i from 31 down to 0:
  - t = (`kalan`<<1) | `mag`[i].
  - `kalan` = (t ≥ `PI_Q`) ? t − `PI_Q` : t.
  - After bit 0, go to DUZELT.
  - Invariant: `kalan` < `PI_Q` after every iteration.
- DUZELT, single cycle:
  - r = `kalan`. If r ≥ (`PI_Q`+1)>>1, then r = r − `PI_Q` (signed), giving r in [−(`PI_Q`>>1), `PI_Q`>>1].
  - If `isaret`, r = −r.
  - `sonuc` ← r, `hazir` ← 1, `gecerli` per the pole rule, then return to BOS.
- Pole rule: `gecerli`=0 if |r| ≥ ((`PI_Q`+1)>>1) − `KUTUP_BANT`; otherwise `gecerli`=1.
- `basla` while `mesgul`=1 is ignored. No queuing occurs and no error is flagged.
- `sayi1` is only sampled on the accepting edge; later changes have no effect on the current operation.
- Arithmetic:
  - All subtractions are done at 33 bits.
  - Negation is two's complement at 32 bits, and the result cannot overflow given the range of r.

## Timing
- Accept edge E0. BOL occupies edges E1–E32. DUZELT executes on E33.
- `hazir` is high for exactly the cycle after E33 and is cleared on E34.
- `mesgul` is high from after E0 until E33, and is low in the cycle where `hazir`=1.
- A new `basla` in the `hazir` cycle is accepted, giving back-to-back throughput of 1 result per 34 cycles.
- `rst` in any state aborts the operation on that edge:
  - All outputs return to reset values and no `hazir` is produced for the aborted operation.
  - `rst` has priority over `basla` on the same edge.
- `sonuc` and `gecerli` are stable between `hazir` pulses.

## Configuration
- `KUTUP_KONTROL_EN` defined: the pole rule above is implemented, and `gecerli` reflects the guard band.
- `KUTUP_KONTROL_EN` undefined: the comparator is omitted and `gecerli` is loaded with 1 on every completion. Its reset value of 0 is unchanged, and `KUTUP_BANT` is unused.

## Test plan
- `sayi1`=65536 (1.0), `basla` pulse → `hazir` 34 cycles after the accept edge, `sonuc`=65536, `gecerli`=1; `mesgul` low during the `hazir` cycle.
- `sayi1`=238655 (π+0.5) → `sonuc`=32768. `sayi1`=131072 (2.0) → `sonuc`=−74815. `sayi1`=0 → `sonuc`=0, `gecerli`=1.
- `sayi1`=−65536 → `sonuc`=−65536. `sayi1`=32'h80000000 → completes with |`sonuc`| ≤ 102943, no X values, `gecerli` consistent with the band.
- Pole, with the macro defined: `sayi1`=102900 → `gecerli`=0, `sonuc`=102900; `sayi1`=102879 → `gecerli`=1. With the macro undefined: both give `gecerli`=1.
- Protocol:
  - `basla` held high for 40 cycles with alternating inputs → exactly one accept per 34 cycles, and each result matches the value sampled at its accept edge.
  - `basla` with `rst` on the same edge → nothing is accepted.
- Assert `rst` at cycle 10 of BOL → all outputs are 0 on the next cycle and no `hazir` appears. A subsequent `basla` with 65536 → `sonuc`=65536.
